// File: rtl/mips_ppu_pkg.sv
// Shared pipeline definitions for the MIPS fetch front end: queue sizing,
// the NOP encoding and the {pc, instr} entry carried from fetch to decode.
package mips_ppu_pkg;

  localparam int unsigned FETCH_Q_DEPTH = 4;
  localparam logic [31:0] MIPS_NOP      = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Occupancy classes of the fetch queue, exposed for debug.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_e;

endpackage

// File: rtl/fetch_queue_ram.sv
// Fetch-queue storage: DEPTH x {pc, instr}, one synchronous write port and
// one asynchronous read port. Contents are never cleared.
module fetch_queue_ram
  import mips_ppu_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_Q_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  fetch_entry_t  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output fetch_entry_t  o_rdata
);

  fetch_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between instruction memory and decode: a FIFO of
// {pc, instr} entries with flush for branch/jump redirects.
module fetch_queue
  import mips_ppu_pkg::*;
#(
  parameter int unsigned DEPTH    = FETCH_Q_DEPTH,
  parameter logic [31:0] NOP_WORD = MIPS_NOP
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               dbg_state
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  occ_state_e    r_state;
  occ_state_e    w_state_nxt;

  logic          w_push;
  logic          w_pop;
  fetch_entry_t  w_wr_entry;
  fetch_entry_t  w_head;

  // Handshake: a transfer happens on a posedge where valid && ready are both
  // high and flush is low. in_ready is a pure function of occupancy, so it
  // never depends on out_ready; a full queue frees a slot only after the pop.
  assign in_ready  = (r_count < FULL_CNT);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  assign w_wr_entry.pc    = in_pc;
  assign w_wr_entry.instr = in_instr;

  fetch_queue_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_entry),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  assign out_pc    = out_valid ? w_head.pc    : 32'h0;
  assign out_instr = out_valid ? w_head.instr : NOP_WORD;
  assign count     = r_count;
  assign dbg_state = r_state;

  // Reset and flush share the discard path; pointers wrap by bit width.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= OCC_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = OCC_EMPTY;
    end else begin
      case (r_state)
        OCC_EMPTY: begin
          if (w_push) w_state_nxt = OCC_PARTIAL;
        end
        OCC_PARTIAL: begin
          if (w_push && !w_pop && (r_count == FULL_CNT - CNT_ONE)) begin
            w_state_nxt = OCC_FULL;
          end else if (w_pop && !w_push && (r_count == CNT_ONE)) begin
            w_state_nxt = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (w_pop && !w_push) w_state_nxt = OCC_PARTIAL;
        end
        default: w_state_nxt = OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, all checked
// every cycle against a queue-based reference model.
module tb_fetch_queue;
  import mips_ppu_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic [2:0]  count;
  logic [1:0]  dbg_state;

  logic [63:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .count     (count),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    int          sz;
    logic [1:0]  occ;
    sz  = exp_q.size();
    occ = (sz == 0) ? OCC_EMPTY : (sz == DEPTH) ? OCC_FULL : OCC_PARTIAL;
    check({tag, ".count"},     64'(count),     64'(sz));
    check({tag, ".in_ready"},  64'(in_ready),  64'(sz < DEPTH));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(sz != 0));
    check({tag, ".out_pc"},    64'(out_pc),    (sz != 0) ? 64'(exp_q[0][63:32]) : 64'h0);
    check({tag, ".out_instr"}, 64'(out_instr), (sz != 0) ? 64'(exp_q[0][31:0])  : 64'h0);
    check({tag, ".state"},     64'(dbg_state), 64'(occ));
  endtask

  // ---------------- driver ----------------
  // Drive one cycle: apply inputs, check pre-edge outputs, clock, update model.
  task automatic cycle(input string tag, input logic v, input logic [31:0] pc,
                       input logic [31:0] ins, input logic rdy, input logic fl,
                       input logic rst);
    bit do_push;
    bit do_pop;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
    reset     = rst;
    #1;
    check_outputs(tag);
    do_push = v && (exp_q.size() < DEPTH) && !fl;
    do_pop  = rdy && (exp_q.size() != 0) && !fl;
    @(posedge clk);
    #1;
    if (rst || fl) begin
      exp_q.delete();
    end else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({pc, ins});
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    @(posedge clk);
    #1;
    cycle("rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle("idle", 2);

    // Fill to full, attempt a fifth push, then drain in order.
    for (int i = 0; i < 4; i++)
      cycle("fill", 1'b1, 32'(i * 4), 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
    cycle("full_push", 1'b1, 32'h10, 32'hA4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle("empty", 1);

    // Full queue under continuous push and pop, across pointer wrap.
    for (int i = 0; i < 4; i++)
      cycle("refill", 1'b1, 32'h200 + 32'(i * 4), 32'hB0 + 32'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      cycle("stream", 1'b1, 32'h300 + 32'(i * 4), 32'hC0 + 32'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      cycle("stream_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush with a simultaneous push at count=2.
    cycle("pre_flush", 1'b1, 32'h20, 32'hD0, 1'b0, 1'b0, 1'b0);
    cycle("pre_flush", 1'b1, 32'h24, 32'hD1, 1'b0, 1'b0, 1'b0);
    cycle("flush", 1'b1, 32'h28, 32'hD2, 1'b1, 1'b1, 1'b0);
    idle("post_flush", 2);

    // Reset mid-stream at count=3 with push and pop requested.
    for (int i = 0; i < 3; i++)
      cycle("pre_rst", 1'b1, 32'h30 + 32'(i * 4), 32'hE0 + 32'(i), 1'b0, 1'b0, 1'b0);
    cycle("mid_rst", 1'b1, 32'h3C, 32'hE3, 1'b1, 1'b0, 1'b1);
    cycle("after_rst", 1'b1, 32'h40, 32'hF0, 1'b0, 1'b0, 1'b0);
    check("first_after_rst", 64'(out_pc), 64'h40);
    cycle("drain_rst", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Push latency: visible only after the push edge.
    idle("lat_idle", 1);
    cycle("lat_push", 1'b1, 32'h100, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    check("lat_pc", 64'(out_pc), 64'h100);
    check("lat_valid", 64'(out_valid), 64'h1);
    cycle("lat_pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      cycle("rand",
            1'($urandom_range(0, 3) != 0),
            {$urandom_range(0, 16'hFFFF), 2'b00} ,
            $urandom,
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 24) == 0),
            1'($urandom_range(0, 59) == 0));
    end
    idle("final", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
